// File: rtl/tt_um_brs_cond_decoder.sv
// Purpose : recovers byte A from a conditional XOR/AND encoded stream using a stored key,
//           flags malformed/ambiguous bytes and keeps a saturating error count.
// Latency : 1 cycle from accepted byte to out_valid pulse; no backpressure (one byte/cycle max).
// Ports   : ui_in = key or encoded byte; uio_in = {unused[3:0], rd_sel, mode, key_load, in_valid};
//           uo_out = decoded byte (rd_sel=0) or error count (rd_sel=1);
//           uio_out = {keyed, ambiguous, byte_err, out_valid, 4'b0}; uio_oe = 8'hF0.
module tt_um_brs_cond_decoder #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_KEYED = 1'b1
  } state_t;

  logic in_vld;
  logic key_load;
  logic mode_in;
  logic rd_sel;

  assign in_vld   = uio_in[0];
  assign key_load = uio_in[1];
  assign mode_in  = uio_in[2];
  assign rd_sel   = uio_in[3];

  // Tile enable and the upper bidir inputs carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  state_t           state_q, state_d;
  logic [7:0]       key_q, key_d;
  logic             mode_q, mode_d;
  logic [7:0]       dec_q, dec_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             out_vld_q, out_vld_d;
  logic             byte_err_q, byte_err_d;
  logic             amb_q, amb_d;

  // Candidate decode of the current byte under the stored key.
  logic [7:0] xor_dat;
  logic [7:0] and_dat;
  logic       xor_err;
  logic       and_err;
  logic       and_amb;

  always_comb begin
    xor_dat = ui_in ^ key_q;
    // Encoder forces A[7]=0 in XOR mode, so a set MSB cannot be genuine.
    xor_err = xor_dat[7];
    // AND mode only happens for A[7]=1; bits where K=0 are lost and read back as 0.
    and_dat = (ui_in & key_q) | 8'h80;
    and_amb = (key_q[6:0] != 7'h7F);
    // Any C bit set where K is clear, or an MSB mismatch, is impossible from a valid encode.
    and_err = ((ui_in & ~key_q) != 8'h00) || (ui_in[7] != key_q[7]);
  end

  logic cnt_inc;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    mode_d     = mode_q;
    dec_d      = dec_q;
    err_cnt_d  = err_cnt_q;
    out_vld_d  = 1'b0;
    byte_err_d = 1'b0;
    amb_d      = 1'b0;
    cnt_inc    = 1'b0;

    if (key_load) begin
      // Key traffic wins over data; these cycles never produce a result.
      if (in_vld) begin
        key_d   = ui_in;
        mode_d  = mode_in;
        state_d = S_KEYED;
      end else begin
        key_d   = 8'h00;
        state_d = S_IDLE;
      end
    end else if (in_vld) begin
      if (state_q == S_IDLE) begin
        // No key to decode with: drop the byte but account for it.
        cnt_inc = 1'b1;
      end else begin
        out_vld_d = 1'b1;
        if (mode_q) begin
          dec_d      = and_dat;
          byte_err_d = and_err;
          amb_d      = and_amb;
        end else begin
          dec_d      = xor_dat;
          byte_err_d = xor_err;
        end
        cnt_inc = byte_err_d;
      end
    end

    if (cnt_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= 8'h00;
      mode_q     <= 1'b0;
      dec_q      <= 8'h00;
      err_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      byte_err_q <= 1'b0;
      amb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      dec_q      <= dec_d;
      err_cnt_q  <= err_cnt_d;
      out_vld_q  <= out_vld_d;
      byte_err_q <= byte_err_d;
      amb_q      <= amb_d;
    end
  end

  // Zero-extend before slicing so any CNT_W yields an 8-bit readback.
  logic [CNT_W+7:0] cnt_ext;
  logic [7:0]       cnt_rd;

  assign cnt_ext = {8'h00, err_cnt_q};
  assign cnt_rd  = cnt_ext[7:0];

  // Readback mux looks only at registered values, so rd_sel never disturbs state.
  assign uo_out  = rd_sel ? cnt_rd : dec_q;
  assign uio_out = {(state_q == S_KEYED), amb_q, byte_err_q, out_vld_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
